// File: rtl/bsr_chain_pkg.sv
// Shared definitions for the boundary-scan register chain: instruction
// encodings, default chain length and the input/output cell index ranges.
package bsr_chain_pkg;

  typedef enum logic [1:0] {
    SAMPLE_PRELOAD = 2'b00,
    EXTEST         = 2'b01,
    INTEST         = 2'b10
  } instr_e;

  localparam int BSR_LEN_DEFAULT = 9;

  localparam int IN_LO  = 0;
  localparam int IN_HI  = 4;
  localparam int OUT_LO = 5;
  localparam int OUT_HI = 8;

endpackage

// File: rtl/bsr_chain_cell.sv
// One boundary-scan bit: a capture/shift flop feeding an update latch-flop.
module bsr_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic capture,
  input  logic shift,
  input  logic update,
  input  logic capture_data,
  input  logic scan_data,
  output logic sr_bit,
  output logic ur_bit
);

  // Capture wins over shift, which wins over update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_bit <= 1'b0;
      ur_bit <= 1'b0;
    end else begin
      if (capture)
        sr_bit <= capture_data;
      else if (shift)
        sr_bit <= scan_data;
      if (update && !capture && !shift)
        ur_bit <= sr_bit;
    end
  end

endmodule

// File: rtl/bsr_chain.sv
// Boundary-scan register chain around a small core; define BSR_PARITY_EN
// to add a parity cell at the LSB of the scan path.
module bsr_chain
  import bsr_chain_pkg::*;
#(
  parameter int BSR_LEN = BSR_LEN_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tdi,
  input  logic       sel,
  input  logic       capture_dr,
  input  logic       shift_dr,
  input  logic       update_dr,
  input  logic [1:0] instr,
  input  logic [4:0] pin_in,
  input  logic [3:0] core_y,
  output logic [4:0] core_x,
  output logic       core_en,
  output logic       core_step,
  output logic [3:0] pin_out,
  output logic       tdo
);

  logic [BSR_LEN-1:0] sr;
  logic [BSR_LEN-1:0] ur;
  logic [BSR_LEN-1:0] cap_vec;
  logic [BSR_LEN-1:0] chain_in;
  logic               cap;
  logic               shf;
  logic               upd;
  logic               step_q;

  assign cap = sel & capture_dr;
  assign shf = sel & shift_dr & ~capture_dr;
  assign upd = sel & update_dr & ~capture_dr & ~shift_dr;

  always_comb begin
    core_x  = '0;
    pin_out = '0;
    core_en = 1'b1;
    case (instr)
      EXTEST: begin
        pin_out = ur[OUT_HI:OUT_LO];
        core_en = 1'b0;
      end
      INTEST: core_x = ur[IN_HI:IN_LO];
      default: begin
        core_x  = pin_in;
        pin_out = core_y;
      end
    endcase
  end

  // Input cells observe what the core actually sees, output cells the core state.
  always_comb begin
    cap_vec                = '0;
    cap_vec[IN_HI:IN_LO]   = core_x;
    cap_vec[OUT_HI:OUT_LO] = core_y;
  end

  assign chain_in = {tdi, sr[BSR_LEN-1:1]};

  for (genvar i = 0; i < BSR_LEN; i++) begin : g_cell
    bsr_cell u_cell (
      .clk          (clk),
      .rst_n        (rst_n),
      .capture      (cap),
      .shift        (sel & shift_dr),
      .update       (sel & update_dr),
      .capture_data (cap_vec[i]),
      .scan_data    (chain_in[i]),
      .sr_bit       (sr[i]),
      .ur_bit       (ur[i])
    );
  end

`ifdef BSR_PARITY_EN
  logic par_q;

  // Parity cell sits below the data cells and never reaches the update register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      par_q <= 1'b0;
    else if (cap)
      par_q <= ^cap_vec;
    else if (shf)
      par_q <= sr[0];
  end

  assign tdo = par_q;
`else
  assign tdo = sr[0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      step_q <= 1'b0;
    else
      step_q <= upd && (instr == INTEST);
  end

  assign core_step = step_q;

endmodule

// File: tb/tb_bsr_chain.sv
// Directed scoreboard bench for bsr_chain: expectations are queued as stimulus
// is applied and popped as the DUT outputs are observed.
`timescale 1ns/1ps
module tb_bsr_chain;
  import bsr_chain_pkg::*;

`ifdef BSR_PARITY_EN
  localparam int CL = 10;
`else
  localparam int CL = 9;
`endif
  localparam int PB = CL - 9;

  logic       clk;
  logic       rst_n;
  logic       tdi;
  logic       sel;
  logic       capture_dr;
  logic       shift_dr;
  logic       update_dr;
  logic [1:0] instr;
  logic [4:0] pin_in;
  logic [3:0] core_y;
  logic [4:0] core_x;
  logic       core_en;
  logic       core_step;
  logic [3:0] pin_out;
  logic       tdo;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  logic [CL-1:0] msr;
  logic [8:0]    mur;
  logic          mstep;

  bsr_chain dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tdi        (tdi),
    .sel        (sel),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr),
    .instr      (instr),
    .pin_in     (pin_in),
    .core_y     (core_y),
    .core_x     (core_x),
    .core_en    (core_en),
    .core_step  (core_step),
    .pin_out    (pin_out),
    .tdo        (tdo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [4:0] exp_core_x();
    case (instr)
      2'b01:   return 5'b0;
      2'b10:   return mur[4:0];
      default: return pin_in;
    endcase
  endfunction

  function automatic logic [3:0] exp_pin_out();
    case (instr)
      2'b01:   return mur[8:5];
      2'b10:   return 4'b0;
      default: return core_y;
    endcase
  endfunction

  function automatic logic exp_core_en();
    return (instr == 2'b01) ? 1'b0 : 1'b1;
  endfunction

  task automatic expectVal(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed);
    exp_t e;
    compared++;
    if (sb.size() == 0) begin
      mismatched++;
      $error("[TB] FAIL %s scoreboard empty observed=%0h", tag, observed);
      return;
    end
    e = sb.pop_front();
    assert (observed === e.val)
    else begin
      mismatched++;
      $error("[TB] FAIL %s/%s observed=%0h expected=%0h", tag, e.tag, observed, e.val);
    end
  endtask

  // Queue the model's view of every output, then compare against the DUT.
  task automatic checkAll(input string tag);
    expectVal({tag, ".core_x"},    16'(exp_core_x()));
    expectVal({tag, ".pin_out"},   16'(exp_pin_out()));
    expectVal({tag, ".core_en"},   16'(exp_core_en()));
    expectVal({tag, ".tdo"},       16'(msr[0]));
    expectVal({tag, ".core_step"}, 16'(mstep));
    checkOutput(tag, 16'(core_x));
    checkOutput(tag, 16'(pin_out));
    checkOutput(tag, 16'(core_en));
    checkOutput(tag, 16'(tdo));
    checkOutput(tag, 16'(core_step));
  endtask

  // Drive one cycle of strobes and advance the reference model across the edge.
  task automatic applyStimulus(input logic s, input logic c, input logic sh,
                               input logic u, input logic d);
    logic [8:0] cv;
    sel        = s;
    capture_dr = c;
    shift_dr   = sh;
    update_dr  = u;
    tdi        = d;
    #1;
    cv    = {core_y, exp_core_x()};
    mstep = 1'b0;
    if (s && c) begin
      msr[CL-1:PB] = cv;
      if (PB == 1) msr[0] = ^cv;
    end else if (s && sh) begin
      msr = {d, msr[CL-1:1]};
    end else if (s && u) begin
      mur   = msr[CL-1:PB];
      mstep = (instr == 2'b10);
    end
    @(posedge clk);
    #1;
    sel        = 1'b0;
    capture_dr = 1'b0;
    shift_dr   = 1'b0;
    update_dr  = 1'b0;
    tdi        = 1'b0;
    #1;
  endtask

  task automatic shiftWord(input string tag, input logic [CL-1:0] w);
    for (int i = 0; i < CL; i++) begin
      expectVal(tag, 16'(msr[0]));
      checkOutput(tag, 16'(tdo));
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, w[i]);
    end
  endtask

  initial begin
    logic [8:0]    seq;
    logic [CL-1:0] pw;
    logic          hist[64];
    int            n;

    rst_n      = 1'b0;
    tdi        = 1'b0;
    sel        = 1'b0;
    capture_dr = 1'b0;
    shift_dr   = 1'b0;
    update_dr  = 1'b0;
    instr      = 2'b00;
    pin_in     = 5'b0;
    core_y     = 4'h0;
    msr        = '0;
    mur        = '0;
    mstep      = 1'b0;

    #12;
    checkAll("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] sample/preload capture and scan-out");
    pin_in = 5'b10111;
    core_y = 4'hA;
    #1;
    expectVal("sp.core_x", 16'h17);
    checkOutput("sp", 16'(core_x));
    expectVal("sp.pin_out", 16'hA);
    checkOutput("sp", 16'(pin_out));
    expectVal("sp.core_en", 16'h1);
    checkOutput("sp", 16'(core_en));
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    seq = 9'b101010111;
    if (PB == 1) begin
      expectVal("sp.tdo_par", 16'h0);
      checkOutput("sp", 16'(tdo));
    end
    pw = CL'(9'b101100000) << PB;
    for (int i = 0; i < CL; i++) begin
      if (i >= PB) begin
        expectVal("sp.tdo_seq", 16'(seq[i-PB]));
        checkOutput("sp", 16'(tdo));
      end
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, pw[i]);
    end
    checkAll("sp_shifted");

    $display("[TB] preload then EXTEST");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkAll("preload_upd");
    instr = 2'b01;
    #1;
    expectVal("ext.pin_out", 16'hB);
    checkOutput("ext", 16'(pin_out));
    expectVal("ext.core_x", 16'h0);
    checkOutput("ext", 16'(core_x));
    expectVal("ext.core_en", 16'h0);
    checkOutput("ext", 16'(core_en));
    checkAll("extest");

    $display("[TB] INTEST update and step pulses");
    instr = 2'b10;
    #1;
    checkAll("intest_pre");
    shiftWord("int.shift", CL'(9'b000010011) << PB);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    expectVal("int.core_x", 16'h13);
    checkOutput("int", 16'(core_x));
    expectVal("int.step_hi", 16'h1);
    checkOutput("int", 16'(core_step));
    checkAll("int_upd");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expectVal("int.step_lo", 16'h0);
    checkOutput("int", 16'(core_step));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkAll("b2b_1");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkAll("b2b_2");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkAll("b2b_idle");

    $display("[TB] coinciding strobes and deselected hold");
    core_y = 4'h5;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    expectVal("coin.core_x", 16'h13);
    checkOutput("coin", 16'(core_x));
    expectVal("coin.step", 16'h0);
    checkOutput("coin", 16'(core_step));
    checkAll("coincide");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    checkAll("shift_over_upd");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    checkAll("sel_low");
    instr = 2'b11;
    #1;
    checkAll("instr_11");

    $display("[TB] long shift pass-through");
    n = 2 * CL + 3;
    for (int k = 0; k < n; k++) begin
      hist[k] = 1'($urandom_range(0, 1));
      if (k >= CL) begin
        expectVal("pass.tdo", 16'(hist[k-CL]));
        checkOutput("pass", 16'(tdo));
      end
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, hist[k]);
    end
    expectVal("pass.tdo_end", 16'(hist[n-CL]));
    checkOutput("pass", 16'(tdo));

    $display("[TB] reset during shift");
    instr  = 2'b00;
    pin_in = 5'b01101;
    core_y = 4'hC;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    msr   = '0;
    mur   = '0;
    mstep = 1'b0;
    #1;
    expectVal("rst.tdo", 16'h0);
    checkOutput("rst", 16'(tdo));
    checkAll("rst_mid");
    instr = 2'b10;
    #1;
    expectVal("rst.core_x", 16'h0);
    checkOutput("rst", 16'(core_x));
    instr = 2'b01;
    #1;
    expectVal("rst.pin_out", 16'h0);
    checkOutput("rst", 16'(pin_out));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] chain length check");
    instr  = 2'b00;
    pin_in = 5'b00001;
    core_y = 4'h0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    expectVal("len.first_tdo", 16'h1);
    checkOutput("len", 16'(tdo));
    for (int k = 0; k < CL; k++) begin
      if (k == CL - 1) begin
        expectVal("len.before_last", 16'(msr[0]));
        checkOutput("len", 16'(tdo));
      end
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, (k == 0));
    end
    expectVal("len.marker", 16'h1);
    checkOutput("len", 16'(tdo));
    checkAll("len_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bsr_chain.md
BSR_CHAIN -- requirements
Module: bsr_chain

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port tdi, input, 1 bit: serial scan data in.
REQ-004 SHALL have port sel, input, 1 bit: boundary register selected by the instruction decoder.
REQ-005 SHALL have ports capture_dr, shift_dr and update_dr, each an input of 1 bit: one-cycle TAP state strobes.
REQ-006 SHALL have port instr, input, 2 bits: 00 SAMPLE_PRELOAD, 01 EXTEST, 10 INTEST, 11 treated as SAMPLE_PRELOAD.
REQ-007 SHALL have port pin_in, input, 5 bits: pad inputs (flag bit 0, tumblers 4:1).
REQ-008 SHALL have port core_y, input, 4 bits: core logic state output.
REQ-009 SHALL have port core_x, output, 5 bits: core logic input.
REQ-010 SHALL have port core_en, output, 1 bit: core logic enable (low holds the core in its reset state).
REQ-011 SHALL have port core_step, output, 1 bit: single-cycle INTEST step pulse.
REQ-012 SHALL have port pin_out, output, 4 bits: pad outputs.
REQ-013 SHALL have port tdo, output, 1 bit: serial scan data out.
REQ-014 SHALL have parameter BSR_LEN, default 9: number of data cells; cells 4:0 are input cells and cells 8:5 are output cells.

Function
REQ-015 SHALL hold a shift register sr[BSR_LEN-1:0] and an update register ur[BSR_LEN-1:0].
REQ-016 Capture (sel & capture_dr) SHALL load sr[4:0] with the current core_x value and sr[8:5] with core_y.
REQ-017 Shift (sel & shift_dr) SHALL perform sr <= {tdi, sr[MSB:1]} every cycle, with the LSB shifted out first.
REQ-018 Update (sel & update_dr) SHALL load ur <= sr; sr SHALL be unchanged.
REQ-019 When strobes coincide, priority SHALL be capture > shift > update; with sel low, sr and ur SHALL hold.
REQ-020 tdo SHALL be combinational sr[0]; when not shifting, tdo SHALL still present sr[0].
REQ-021 In SAMPLE_PRELOAD: core_x SHALL equal pin_in, pin_out SHALL equal core_y, and core_en SHALL be 1.
REQ-022 In EXTEST: core_x SHALL be 5'b0, pin_out SHALL equal ur[8:5], and core_en SHALL be 0.
REQ-023 In INTEST: core_x SHALL equal ur[4:0], pin_out SHALL be 4'b0 (safe), and core_en SHALL be 1.
REQ-024 core_step SHALL be registered and assert for exactly one cycle, the cycle after an update strobe that occurs while instr==INTEST.
REQ-025 Back-to-back updates SHALL produce one core_step pulse per update.
REQ-026 An instr change SHALL take effect on the core_x, pin_out and core_en muxes combinationally; it SHALL NOT alter sr or ur.
REQ-027 A shift of more than BSR_LEN cycles SHALL simply pass tdi through to tdo with a delay of BSR_LEN cycles.

Reset
REQ-028 While rst_n is low: sr=0, ur=0, core_step=0; the outputs follow REQ-021..023 using those zero values.
REQ-029 rst_n assertion mid-shift SHALL discard the partial shift immediately, with no wait for a clock edge.

Configuration
REQ-030 With macro BSR_PARITY_EN defined, the chain SHALL gain one extra cell at the LSB (total BSR_LEN+1 cells).
REQ-031 On capture, the extra cell SHALL load the XOR of the captured 9 bits; it SHALL shift like any other cell and SHALL be excluded from ur.
REQ-032 With BSR_PARITY_EN undefined, the chain SHALL be exactly BSR_LEN cells and tdo SHALL be sr[0] of the data cells.

Structure
REQ-033 A shared package SHALL hold the instr encodings (SAMPLE_PRELOAD, EXTEST, INTEST), the BSR_LEN default, and the input/output cell index ranges.
REQ-034 One sub-module, bsr_cell (a single capture/shift/update bit), SHALL be instantiated per cell via generate.

Verification
REQ-035 Reset, then SAMPLE_PRELOAD with pin_in=5'b10111 and core_y=4'hA -> core_x=10111, pin_out=1010, core_en=1; after capture and 9 shifts, the tdo sequence SHALL be 1,1,1,0,1,0,1,0,1.
REQ-036 Preload by shifting in 9'b1_0110_0000, then update, then instr=EXTEST -> pin_out=4'b1011, core_x=0, core_en=0.
REQ-037 INTEST: shift in 9'b0000_1001_1 (ur[4:0]=5'b10011), then update -> core_x=10011 and core_step high for exactly 1 cycle, one cycle after update_dr.
REQ-038 Capture, shift_dr and update_dr asserted in the same cycle -> only the capture occurs, ur is unchanged, and no core_step pulse is produced.
REQ-039 rst_n dropped after 4 of 9 shifts -> sr=0 and ur=0 immediately; tdo=0.
REQ-040 With BSR_PARITY_EN defined, capture with pin_in=5'b00001 and core_y=4'h0 -> the first tdo bit SHALL be 1, and the total shift length SHALL be 10 cycles.
